// File: rtl/sine_pwm_dac.sv
// sine_pwm_dac: replays offset-binary samples from a one-entry buffer as PWM periods,
// repeating the last duty and counting an underrun whenever the buffer is empty at a boundary.
module sine_pwm_dac #(
   parameter int DATA_W     = 8,
   parameter int PRESCALE   = 1,
   parameter int UNDERRUN_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_W-1:0]     sample_in,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic                  pwm_out,
   output logic                  period_start,
   output logic [DATA_W-1:0]     active_sample,
   output logic                  underrun,
   output logic [UNDERRUN_W-1:0] underrun_count,
   input  logic                  clr_status
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   logic hold_valid, hold_valid_n, accept, pre_wrap, period_end, take, starve, underrun_n, start_n;
   logic [DATA_W-1:0] hold, cnt, cnt_n, active_n;
   logic [PW-1:0] pre, pre_n;
   logic [UNDERRUN_W-1:0] count_base, count_n;
   assign sample_ready = !hold_valid && !reset;
   assign accept = sample_valid && sample_ready;
   assign pre_wrap = pre == PRE_MAX;
   assign period_end = state == RUN && pre_wrap && &cnt;
   assign take = enable && hold_valid && (state == IDLE || period_end);
   assign starve = enable && !hold_valid && period_end;
   // an underrun on the same edge as clr_status counts from a cleared base
   assign count_base = clr_status ? '0 : underrun_count;
   always_comb begin
      state_n = period_end && !enable ? IDLE : take ? RUN : state;
      pre_n = state == RUN && !pre_wrap ? pre + 1'b1 : '0;
      cnt_n = state == RUN ? cnt + DATA_W'(pre_wrap) : '0;
      active_n = take ? hold : active_sample;
      hold_valid_n = accept || (hold_valid && !take);
      start_n = take || starve;
      underrun_n = starve || (underrun && !clr_status);
      count_n = starve && !(&count_base) ? count_base + 1'b1 : count_base;
   end
   // pwm_out is registered from next-state values so it tracks cnt < active_sample glitch-free
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         hold_valid <= 1'b0;
         hold <= '0;
         cnt <= '0;
         pre <= '0;
         active_sample <= '0;
         pwm_out <= 1'b0;
         period_start <= 1'b0;
         underrun <= 1'b0;
         underrun_count <= '0;
      end else begin
         state <= state_n;
         hold_valid <= hold_valid_n;
         hold <= accept ? sample_in : hold;
         cnt <= cnt_n;
         pre <= pre_n;
         active_sample <= active_n;
         pwm_out <= state_n == RUN && cnt_n < active_n;
         period_start <= start_n;
         underrun <= underrun_n;
         underrun_count <= count_n;
      end
   end
endmodule

// File: tb/tb_sine_pwm_dac.sv
// tb_sine_pwm_dac: directed and randomized checks of sine_pwm_dac against a
// period-offset reference model, for PRESCALE=1 and PRESCALE=4 instances.
module tb_sine_pwm_dac;
   logic clk = 0, reset = 1, enable = 0, sample_valid = 0, clr_status = 0;
   logic [7:0] sample_in = 0;
   logic rdy1, pwm1, ps1, ur1, rdy4, pwm4, ps4, ur4;
   logic [7:0] act1, act4;
   logic [15:0] urc1, urc4;
   logic rdy, pwm, ps, ur;
   logic [7:0] act;
   logic [15:0] urc;
   int sel_p = 1;
   int tests = 0, fails = 0;
   logic [7:0] feed[$];
   bit m_valid = 0, m_run = 0, m_ur = 0, m_ps = 0;
   logic [7:0] m_hold = 0, m_duty = 0;
   int m_t = 0, m_urc = 0;
   int mism = 0, since_ps = 0, highs = 0, ps_cnt = 0, g;
   bit have_prev = 0;
   int ps_gap[$], ps_high[$], ps_act[$], ps_ur[$];
   always #5 clk = ~clk;
   sine_pwm_dac #(.DATA_W(8), .PRESCALE(1), .UNDERRUN_W(16)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
      .sample_valid(sample_valid), .sample_ready(rdy1), .pwm_out(pwm1),
      .period_start(ps1), .active_sample(act1), .underrun(ur1),
      .underrun_count(urc1), .clr_status(clr_status));
   sine_pwm_dac #(.DATA_W(8), .PRESCALE(4), .UNDERRUN_W(16)) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
      .sample_valid(sample_valid), .sample_ready(rdy4), .pwm_out(pwm4),
      .period_start(ps4), .active_sample(act4), .underrun(ur4),
      .underrun_count(urc4), .clr_status(clr_status));
   always_comb begin
      rdy = sel_p == 4 ? rdy4 : rdy1;
      pwm = sel_p == 4 ? pwm4 : pwm1;
      ps = sel_p == 4 ? ps4 : ps1;
      ur = sel_p == 4 ? ur4 : ur1;
      act = sel_p == 4 ? act4 : act1;
      urc = sel_p == 4 ? urc4 : urc1;
   end
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic drive();
      sample_valid = feed.size() > 0;
      sample_in = feed.size() > 0 ? feed[0] : 8'h00;
   endtask
   // model tracks the clock offset m_t within a period of 256*P clocks
   task automatic tick();
      bit acc, e_pwm, e_rdy;
      int l;
      acc = sample_valid && !m_valid && !reset;
      l = 256 * sel_p;
      @(posedge clk);
      #1;
      m_ps = 0;
      if (reset) begin
         m_valid = 0; m_run = 0; m_t = 0; m_duty = 0; m_ur = 0; m_urc = 0;
      end else begin
         if (clr_status) begin m_ur = 0; m_urc = 0; end
         if (!m_run) begin
            if (enable && m_valid) begin
               m_run = 1; m_t = 0; m_duty = m_hold; m_valid = 0; m_ps = 1;
            end
         end else if (m_t < l - 1) m_t++;
         else begin
            m_t = 0;
            if (!enable) m_run = 0;
            else begin
               m_ps = 1;
               if (m_valid) begin m_duty = m_hold; m_valid = 0; end
               else begin m_ur = 1; if (m_urc < 65535) m_urc++; end
            end
         end
         if (acc) begin m_valid = 1; m_hold = sample_in; end
      end
      if (acc) void'(feed.pop_front());
      e_pwm = m_run && (m_t < int'(m_duty) * sel_p);
      e_rdy = !m_valid && !reset;
      if ({pwm, ps, ur, act, urc, rdy} !== {e_pwm, m_ps, m_ur, m_duty, 16'(m_urc), e_rdy}) mism++;
      if (ps) begin
         if (have_prev) begin ps_gap.push_back(since_ps); ps_high.push_back(highs); end
         have_prev = 1; since_ps = 0; highs = 0; ps_cnt++;
         ps_act.push_back(int'(act)); ps_ur.push_back(int'(ur));
      end
      since_ps++;
      highs += int'(pwm);
      drive();
   endtask
   task automatic run(input int n);
      repeat (n) tick();
   endtask
   task automatic start_phase(input int p);
      reset = 1; enable = 0; clr_status = 0; sel_p = p;
      feed.delete();
      drive();
      run(2);
      reset = 0;
      mism = 0; since_ps = 0; highs = 0; ps_cnt = 0; have_prev = 0;
      ps_gap.delete(); ps_high.delete(); ps_act.delete(); ps_ur.delete();
   endtask
   initial begin
      // reset holds everything at zero and ignores an offered sample
      feed.push_back(8'hAA);
      drive();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("rst_ready", rdy, 0);
         check("rst_outputs", {pwm, ps, ur, act, urc}, 0);
      end
      reset = 0;
      #1;
      check("rst_release_ready", rdy, 1);
      feed.delete();
      drive();
      tick();
      check("rst_nothing_captured", {rdy, act}, {1'b1, 8'h00});
      check("lockstep_reset", mism, 0);
      // continuous stream of duty 64
      start_phase(1);
      enable = 1;
      repeat (5) feed.push_back(8'd64);
      drive();
      run(1100);
      for (int i = 0; i < 4; i++) begin
         check("stream_gap", ps_gap[i], 256);
         check("stream_high", ps_high[i], 64);
         check("stream_act", ps_act[i], 64);
      end
      check("stream_no_underrun", ur, 0);
      check("lockstep_stream", mism, 0);
      // extreme duties
      start_phase(1);
      enable = 1;
      feed = '{8'd0, 8'd255, 8'd128, 8'd128};
      drive();
      run(1100);
      check("duty0_high", ps_high[0], 0);
      check("duty255_high", ps_high[1], 255);
      check("duty128_high", ps_high[2], 128);
      check("duty255_gap", ps_gap[1], 256);
      check("act_seq", {ps_act[0][7:0], ps_act[1][7:0], ps_act[2][7:0]}, {8'd0, 8'd255, 8'd128});
      check("lockstep_duty", mism, 0);
      // single sample then starvation
      start_phase(1);
      enable = 1;
      feed.push_back(8'd100);
      drive();
      g = 0;
      while (ps_cnt < 4 && g < 5000) begin tick(); g++; end
      check("ur_wait_bound", g < 5000, 1);
      check("ur_count3", urc, 3);
      check("ur_flags", {ps_ur[0][0], ps_ur[1][0], ps_ur[2][0], ps_ur[3][0]}, 4'b0111);
      for (int i = 0; i < 3; i++) check("ur_repeat_high", ps_high[i], 100);
      check("ur_act", act, 100);
      clr_status = 1;
      tick();
      clr_status = 0;
      check("clr_alone", {ur, urc}, 0);
      g = 0;
      while (!(m_run && m_t == 255) && g < 1000) begin tick(); g++; end
      check("clr_wait_bound", g < 1000, 1);
      clr_status = 1;
      tick();
      clr_status = 0;
      check("clr_vs_underrun", {ur, urc}, {1'b1, 16'd1});
      check("lockstep_underrun", mism, 0);
      // prescaled period
      start_phase(4);
      enable = 1;
      feed = '{8'd10, 8'd10, 8'd10};
      drive();
      run(2200);
      for (int i = 0; i < 2; i++) begin
         check("pre4_gap", ps_gap[i], 1024);
         check("pre4_high", ps_high[i], 40);
      end
      check("lockstep_pre4", mism, 0);
      // enable dropped mid-period with a sample buffered
      start_phase(1);
      enable = 1;
      feed = '{8'd200, 8'd77};
      drive();
      g = 0;
      while (!(m_run && m_t == 100) && g < 1000) begin tick(); g++; end
      check("drop_wait_bound", g < 1000, 1);
      check("drop_buffered", rdy, 0);
      enable = 0;
      ps_cnt = 0;
      run(400);
      check("drop_no_start", ps_cnt, 0);
      check("drop_no_underrun", ur, 0);
      check("drop_pwm_low", pwm, 0);
      check("drop_period_done", highs, 200);
      check("drop_retained", rdy, 0);
      enable = 1;
      g = 0;
      while (ps_cnt < 1 && g < 100) begin tick(); g++; end
      check("reen_wait_bound", g < 100, 1);
      check("reen_act", act, 77);
      run(255);
      check("reen_high", highs, 77);
      check("lockstep_enable", mism, 0);
      // random traffic, enables, clears and resets against the model
      for (int r = 0; r < 2; r++) begin
         start_phase(r == 0 ? 1 : 4);
         enable = 1;
         for (int c = 0; c < (r == 0 ? 6000 : 12000); c++) begin
            if ($urandom_range(0, 299) == 0) enable = $urandom_range(0, 3) != 0;
            if (feed.size() == 0 && $urandom_range(0, 299) < 2) feed.push_back(8'($urandom));
            clr_status = $urandom_range(0, 499) == 0;
            reset = $urandom_range(0, 1999) == 0;
            drive();
            tick();
         end
         reset = 0;
         clr_status = 0;
         check("rand_periods", ps_cnt > 0, 1);
         check(r == 0 ? "lockstep_rand_p1" : "lockstep_rand_p4", mism, 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
